// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl
// Brief    : Fetch PC sequencer with redirect handling, in-flight response
//            discard and a registered response FIFO toward decode.
//            Optional misaligned-fetch trap: FETCH_ADEL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_valid,
   input  logic [31:0] flush_pc,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        fe_valid,
   output logic [31:0] fe_pc,
   output logic [31:0] fe_inst,
   output logic        fe_adel,
   input  logic        fe_ready
);

   localparam int              c_CW    = $clog2(DEPTH + 1);
   localparam int              c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_CW:0]   c_DEPTH = (c_CW + 1)'(DEPTH);
   localparam logic [c_IW-1:0] c_LAST  = c_IW'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_RUN       = 1'b0,
      S_WAIT_ADDR = 1'b1
   } state_t;

   state_t          r_state;
   logic [31:0]     r_pc;
   logic [31:0]     r_req_pc;
   logic [c_CW-1:0] r_outs_cnt;
   logic [c_CW-1:0] r_disc_cnt;
   logic [c_CW-1:0] r_fifo_cnt;
   logic            r_pend_kill;
   logic [31:0]     r_pcq [DEPTH];
   logic [c_IW-1:0] r_pcq_wr;
   logic [c_IW-1:0] r_pcq_rd;
   logic [31:0]     r_fq_pc [DEPTH];
   logic [31:0]     r_fq_inst [DEPTH];
   logic [c_IW-1:0] r_fq_wr;
   logic [c_IW-1:0] r_fq_rd;

   logic            w_redirect;
   logic [31:0]     w_target;
   logic            w_acc;
   logic            w_ret;
   logic            w_pop;
   logic [c_CW:0]   w_used;
   logic            w_room;
   logic            w_run_req;
   logic [31:0]     w_req_pc;
   logic            w_drop;
   logic            w_fq_push;
   logic            w_adel_push;
   logic            w_misalign;
   logic            w_hold;

   function automatic logic [c_IW-1:0] f_inc(input logic [c_IW-1:0] p);
      return (p == c_LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_redirect = flush_valid | br_valid;
   assign w_target   = flush_valid ? flush_pc : br_target;
   assign w_acc      = inst_req & inst_addr_ok;
   assign w_ret      = inst_data_ok;
   assign w_pop      = fe_valid & fe_ready;
   assign w_req_pc   = (r_state == S_WAIT_ADDR) ? r_req_pc : r_pc;

   // A slot popped by decode this cycle is free before any new response can land,
   // which is what lets DEPTH=2 sustain one instruction per cycle.
   assign w_used = {1'b0, r_outs_cnt} + {1'b0, r_fifo_cnt} - {{c_CW{1'b0}}, w_pop};
   assign w_room = w_used < c_DEPTH;

   assign w_run_req = (r_state == S_RUN) & ~w_redirect & w_room & ~w_misalign & ~w_hold;
   assign inst_req  = ~reset & ((r_state == S_WAIT_ADDR) | w_run_req);

   assign w_drop    = w_ret & ~w_redirect & (r_disc_cnt != '0);
   assign w_fq_push = (w_ret & ~w_redirect & (r_disc_cnt == '0)) | w_adel_push;

   assign fe_valid = ~reset & ~w_redirect & (r_fifo_cnt != '0);
   assign fe_pc    = r_fq_pc[r_fq_rd];
   assign fe_inst  = r_fq_inst[r_fq_rd];

`ifdef FETCH_ADEL_CHECK_EN
   logic [DEPTH-1:0] r_fq_adel;
   logic             r_adel_hold;

   assign w_misalign  = (r_pc[1:0] != 2'b00);
   assign w_hold      = r_adel_hold;
   assign w_adel_push = (r_state == S_RUN) & ~w_redirect & w_misalign & ~r_adel_hold &
                        (r_outs_cnt == '0) & ({1'b0, r_fifo_cnt} < c_DEPTH);
   assign inst_addr   = w_req_pc;
   assign fe_adel     = r_fq_adel[r_fq_rd];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fq_adel   <= '0;
         r_adel_hold <= 1'b0;
      end else begin
         if (w_redirect) begin
            r_adel_hold <= 1'b0;
         end else if (w_adel_push) begin
            r_adel_hold <= 1'b1;
         end
         if (!w_redirect && w_fq_push) begin
            r_fq_adel[r_fq_wr] <= w_adel_push;
         end
      end
   end
`else
   assign w_misalign  = 1'b0;
   assign w_hold      = 1'b0;
   assign w_adel_push = 1'b0;
   assign inst_addr   = {w_req_pc[31:2], 2'b00};
   assign fe_adel     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_pc        <= RESET_PC;
         r_req_pc    <= RESET_PC;
         r_outs_cnt  <= '0;
         r_disc_cnt  <= '0;
         r_fifo_cnt  <= '0;
         r_pend_kill <= 1'b0;
         r_pcq_wr    <= '0;
         r_pcq_rd    <= '0;
         r_fq_wr     <= '0;
         r_fq_rd     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pcq[i]     <= '0;
            r_fq_pc[i]   <= '0;
            r_fq_inst[i] <= '0;
         end
      end else begin
         case (r_state)
            S_RUN: begin
               if (inst_req && !inst_addr_ok) begin
                  r_state  <= S_WAIT_ADDR;
                  r_req_pc <= r_pc;
               end
            end
            S_WAIT_ADDR: begin
               if (inst_addr_ok) begin
                  r_state <= S_RUN;
               end
            end
            default: r_state <= S_RUN;
         endcase

         // A killed request finally accepted must not advance the redirected PC.
         if (w_redirect) begin
            r_pc <= w_target;
         end else if (w_acc && !r_pend_kill) begin
            r_pc <= r_pc + 32'd4;
         end

         if (w_redirect) begin
            r_pend_kill <= (r_state == S_WAIT_ADDR) & ~inst_addr_ok;
         end else if (w_acc) begin
            r_pend_kill <= 1'b0;
         end

         r_outs_cnt <= r_outs_cnt + c_CW'(w_acc) - c_CW'(w_ret);

         if (w_redirect) begin
            r_disc_cnt <= r_outs_cnt + c_CW'(w_acc) - c_CW'(w_ret);
         end else begin
            r_disc_cnt <= r_disc_cnt + c_CW'(w_acc & r_pend_kill) - c_CW'(w_drop);
         end

         if (w_acc) begin
            r_pcq[r_pcq_wr] <= w_req_pc;
            r_pcq_wr        <= f_inc(r_pcq_wr);
         end
         if (w_ret) begin
            r_pcq_rd <= f_inc(r_pcq_rd);
         end

         if (w_redirect) begin
            r_fq_wr    <= '0;
            r_fq_rd    <= '0;
            r_fifo_cnt <= '0;
         end else begin
            if (w_fq_push) begin
               r_fq_pc[r_fq_wr]   <= w_adel_push ? r_pc : r_pcq[r_pcq_rd];
               r_fq_inst[r_fq_wr] <= w_adel_push ? 32'h0 : inst_rdata;
               r_fq_wr            <= f_inc(r_fq_wr);
            end
            if (w_pop) begin
               r_fq_rd <= f_inc(r_fq_rd);
            end
            r_fifo_cnt <= r_fifo_cnt + c_CW'(w_fq_push) - c_CW'(w_pop);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_ctrl
// Brief    : Directed self-checking bench for fetch_redirect_ctrl with an
//            in-order bridge model returning rdata = ~addr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

   logic        clk;
   logic        reset;
   logic        flush_valid;
   logic [31:0] flush_pc;
   logic        br_valid;
   logic [31:0] br_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        fe_valid;
   logic [31:0] fe_pc;
   logic [31:0] fe_inst;
   logic        fe_adel;
   logic        fe_ready;

   logic        aok;
   logic        dok;
   bit          saw_bad;
   logic [31:0] q [$];
   int          n_cmp;
   int          n_err;

   fetch_redirect_ctrl #(
      .DEPTH    (2),
      .RESET_PC (32'hBFC00000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush_valid  (flush_valid),
      .flush_pc     (flush_pc),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .fe_valid     (fe_valid),
      .fe_pc        (fe_pc),
      .fe_inst      (fe_inst),
      .fe_adel      (fe_adel),
      .fe_ready     (fe_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign inst_addr_ok = aok & inst_req;

   // Bridge: accepts on addr_ok, answers one cycle later in order when dok is set.
   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         inst_data_ok <= 1'b0;
         inst_rdata   <= 32'h0;
      end else begin
         if (inst_req && inst_addr_ok) begin
            q.push_back(inst_addr);
            if (inst_addr == 32'hBFC00100) saw_bad = 1'b1;
         end
         if (dok && q.size() > 0) begin
            inst_data_ok <= 1'b1;
            inst_rdata   <= ~q.pop_front();
         end else begin
            inst_data_ok <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_fe(input string tag, input int budget);
      int k = 0;
      while (fe_valid !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      chk(tag, 32'(fe_valid), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp = 0; n_err = 0; saw_bad = 1'b0;
      reset = 1'b1; aok = 1'b0; dok = 1'b0; fe_ready = 1'b0;
      flush_valid = 1'b0; flush_pc = 32'h0; br_valid = 1'b0; br_target = 32'h0;

      // reset state and hold of the first request
      step(); step();
      chk("rst_inst_req", 32'(inst_req), 32'd0);
      chk("rst_fe_valid", 32'(fe_valid), 32'd0);
      chk("rst_fe_pc", fe_pc, 32'h0);
      chk("rst_fe_inst", fe_inst, 32'h0);
      chk("rst_fe_adel", 32'(fe_adel), 32'd0);
      reset = 1'b0;
      #1;
      chk("first_req", 32'(inst_req), 32'd1);
      chk("first_addr", inst_addr, 32'hBFC00000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_req", 32'(inst_req), 32'd1);
         chk("hold_addr", inst_addr, 32'hBFC00000);
         chk("hold_fe_valid", 32'(fe_valid), 32'd0);
         chk("hold_outs", 32'(dut.r_outs_cnt), 32'd0);
      end

      // full-rate stream
      aok = 1'b1; dok = 1'b1; fe_ready = 1'b1;
      step();
      chk("str_fv_n1", 32'(fe_valid), 32'd0);
      step();
      chk("str_fv0", 32'(fe_valid), 32'd1);
      chk("str_pc0", fe_pc, 32'hBFC00000);
      chk("str_inst0", fe_inst, 32'h403FFFFF);
      step();
      chk("str_fv1", 32'(fe_valid), 32'd1);
      chk("str_pc1", fe_pc, 32'hBFC00004);
      chk("str_inst1", fe_inst, 32'h403FFFFB);
      step();
      chk("str_fv2", 32'(fe_valid), 32'd1);
      chk("str_pc2", fe_pc, 32'hBFC00008);
      chk("str_inst2", fe_inst, 32'h403FFFF7);

      // reset mid-stream, then flush with two requests in flight
      reset = 1'b1;
      step();
      chk("mid_rst_req", 32'(inst_req), 32'd0);
      chk("mid_rst_fv", 32'(fe_valid), 32'd0);
      reset = 1'b0; aok = 1'b1; dok = 1'b0; fe_ready = 1'b1;
      step(); step();
      chk("cap_req", 32'(inst_req), 32'd0);
      flush_valid = 1'b1; flush_pc = 32'hBFC00380; dok = 1'b1;
      #1;
      chk("fl2_req", 32'(inst_req), 32'd0);
      step();
      flush_valid = 1'b0;
      #1;
      chk("fl2_full_req", 32'(inst_req), 32'd0);
      step();
      chk("fl2_new_req", 32'(inst_req), 32'd1);
      chk("fl2_new_addr", inst_addr, 32'hBFC00380);
      wait_fe("fl2_fv", 20);
      chk("fl2_fe_pc", fe_pc, 32'hBFC00380);
      chk("fl2_fe_inst", fe_inst, 32'h403FFC7F);

      // flush while waiting for addr_ok on 0xBFC00010
      reset = 1'b1;
      step();
      reset = 1'b0; aok = 1'b1; dok = 1'b1; fe_ready = 1'b1;
      step(); step(); step(); step();
      chk("wa_addr", inst_addr, 32'hBFC00010);
      aok = 1'b0;
      step();
      chk("wa_pre_fv", 32'(fe_valid), 32'd1);
      chk("wa_pre_pc", fe_pc, 32'hBFC0000C);
      flush_valid = 1'b1; flush_pc = 32'hBFC00380;
      #1;
      chk("wa_fv_forced", 32'(fe_valid), 32'd0);
      chk("wa_req_held", 32'(inst_req), 32'd1);
      step();
      flush_valid = 1'b0;
      #1;
      chk("wa_frz1", inst_addr, 32'hBFC00010);
      step();
      chk("wa_frz2", inst_addr, 32'hBFC00010);
      step();
      chk("wa_frz3", inst_addr, 32'hBFC00010);
      aok = 1'b1;
      step();
      chk("wa_next_req", 32'(inst_req), 32'd1);
      chk("wa_next_addr", inst_addr, 32'hBFC00380);
      wait_fe("wa_fv", 20);
      chk("wa_fe_pc", fe_pc, 32'hBFC00380);

      // flush and branch together; then a lone branch while streaming
      reset = 1'b1;
      step();
      reset = 1'b0; aok = 1'b1; dok = 1'b1; fe_ready = 1'b1;
      step();
      flush_valid = 1'b1; flush_pc = 32'h80001000;
      br_valid = 1'b1; br_target = 32'hBFC00100;
      #1;
      chk("pri_req", 32'(inst_req), 32'd0);
      step();
      flush_valid = 1'b0; br_valid = 1'b0;
      #1;
      chk("pri_new_req", 32'(inst_req), 32'd1);
      chk("pri_new_addr", inst_addr, 32'h80001000);
      wait_fe("pri_fv", 20);
      chk("pri_fe_pc", fe_pc, 32'h80001000);
      chk("pri_fe_inst", fe_inst, 32'h7FFFEFFF);
      br_valid = 1'b1; br_target = 32'hBFC00200;
      #1;
      chk("br_fv_forced", 32'(fe_valid), 32'd0);
      step();
      br_valid = 1'b0;
      wait_fe("br_fv", 20);
      chk("br_fe_pc", fe_pc, 32'hBFC00200);
      chk("br_fe_inst", fe_inst, 32'h403FFDFF);
      repeat (4) step();
      chk("pri_no_br_tgt", 32'(saw_bad), 32'd0);

      // redirect to a misaligned address
      reset = 1'b1;
      step();
      reset = 1'b0; aok = 1'b1; dok = 1'b1; fe_ready = 1'b0;
      flush_valid = 1'b1; flush_pc = 32'h80000002;
      #1;
      chk("mis_fl_req", 32'(inst_req), 32'd0);
      step();
      flush_valid = 1'b0;
      #1;
`ifdef FETCH_ADEL_CHECK_EN
      chk("adel_no_req", 32'(inst_req), 32'd0);
      wait_fe("adel_fv", 10);
      chk("adel_flag", 32'(fe_adel), 32'd1);
      chk("adel_pc", fe_pc, 32'h80000002);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("adel_stall_req", 32'(inst_req), 32'd0);
      end
`else
      chk("mis_req", 32'(inst_req), 32'd1);
      chk("mis_addr", inst_addr, 32'h80000000);
      wait_fe("mis_fv", 10);
      chk("mis_adel", 32'(fe_adel), 32'd0);
      chk("mis_pc", fe_pc, 32'h80000002);
      chk("mis_inst", fe_inst, 32'h7FFFFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
